// File: rtl/sync_fifo_v3.sv
// Single-clock pointer FIFO with selectable FWFT / registered read, fill count,
// almost-full/empty thresholds, sticky overflow/underflow flags and synchronous flush.
module sync_fifo_v3 #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LEN = 4,
    parameter bit FWFT      = 1'b1,
    parameter int AF_THRESH = 12,
    parameter int AE_THRESH = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_flush,
    input  logic               i_clr_err,
    input  logic [WIDTH-1:0]   i_data,
    input  logic               wr_en,
    input  logic               rd_en,
    output logic [WIDTH-1:0]   o_data,
    output logic               o_rd_valid,
    output logic               o_full,
    output logic               o_empty,
    output logic               o_almost_full,
    output logic               o_almost_empty,
    output logic [DEPTH_LEN:0] o_count,
    output logic               o_overflow,
    output logic               o_underflow
);

    localparam int DEPTH = 1 << DEPTH_LEN;
    localparam logic [DEPTH_LEN:0] DEPTH_CNT = DEPTH[DEPTH_LEN:0];
    localparam logic [DEPTH_LEN:0] AF_CNT    = AF_THRESH[DEPTH_LEN:0];
    localparam logic [DEPTH_LEN:0] AE_CNT    = AE_THRESH[DEPTH_LEN:0];

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LEN:0]   wr_ptr;
    logic [DEPTH_LEN:0]   rd_ptr;
    logic [DEPTH_LEN-1:0] wr_idx;
    logic [DEPTH_LEN-1:0] rd_idx;
    logic                 wr_req;
    logic                 rd_req;
    logic                 wr_err;
    logic                 rd_err;

    // The extra pointer MSB makes the modular difference span 0..DEPTH.
    assign o_count        = wr_ptr - rd_ptr;
    assign o_full         = (o_count == DEPTH_CNT);
    assign o_empty        = (o_count == '0);
    assign o_almost_full  = (o_count >= AF_CNT);
    assign o_almost_empty = (o_count <= AE_CNT);

    assign wr_idx = wr_ptr[DEPTH_LEN-1:0];
    assign rd_idx = rd_ptr[DEPTH_LEN-1:0];

    // Flush masks both request types, including their error side effects.
    assign wr_req = wr_en & ~o_full  & ~i_flush;
    assign rd_req = rd_en & ~o_empty & ~i_flush;
    assign wr_err = wr_en &  o_full  & ~i_flush;
    assign rd_err = rd_en &  o_empty & ~i_flush;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_req) wr_ptr <= wr_ptr + 1'b1;
                if (rd_req) rd_ptr <= rd_ptr + 1'b1;
            end

            if (wr_err)         o_overflow <= 1'b1;
            else if (i_clr_err) o_overflow <= 1'b0;

            if (rd_err)         o_underflow <= 1'b1;
            else if (i_clr_err) o_underflow <= 1'b0;
        end
    end

    // NOTE: storage has no reset; validity is tracked purely by the pointers,
    // which keeps the array mappable to RAM.
    always_ff @(posedge i_clk) begin
        if (wr_req) mem[wr_idx] <= i_data;
    end

    generate
        if (FWFT) begin : g_fwft
            // Masked when empty so the output is a defined zero out of reset.
            assign o_data     = o_empty ? '0 : mem[rd_idx];
            assign o_rd_valid = ~o_empty;
        end else begin : g_std
            logic [WIDTH-1:0] data_q;
            logic             valid_q;

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    data_q  <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= rd_req;
                    if (rd_req) data_q <= mem[rd_idx];
                end
            end

            assign o_data     = data_q;
            assign o_rd_valid = valid_q;
        end
    endgenerate

    a_count_range: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_count <= DEPTH_CNT);
    a_no_write_when_full: assert property (@(posedge i_clk) disable iff (!i_rst_n)
        o_full && !i_flush |=> $stable(wr_ptr) || $past(rd_req));

endmodule

// File: tb/tb_sync_fifo_v3.sv
// Scoreboard bench: one FWFT and one standard-mode FIFO driven by directed vectors;
// monitors pop expected words whenever a DUT presents read data.
module tb_sync_fifo_v3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;

    // FWFT instance signals
    logic       flush_a = 0, clr_a = 0, wr_a = 0, rd_a = 0;
    logic [7:0] din_a = 0, dout_a;
    logic       valid_a, full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
    logic [4:0] count_a;

    // Standard-mode instance signals
    logic       flush_b = 0, clr_b = 0, wr_b = 0, rd_b = 0;
    logic [7:0] din_b = 0, dout_b;
    logic       valid_b, full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
    logic [4:0] count_b;

    logic [7:0] q_a[$];
    logic [7:0] q_b[$];

    sync_fifo_v3 #(.WIDTH(8), .DEPTH_LEN(4), .FWFT(1'b1), .AF_THRESH(12), .AE_THRESH(2)) dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_a), .i_clr_err(clr_a),
        .i_data(din_a), .wr_en(wr_a), .rd_en(rd_a), .o_data(dout_a),
        .o_rd_valid(valid_a), .o_full(full_a), .o_empty(empty_a),
        .o_almost_full(af_a), .o_almost_empty(ae_a), .o_count(count_a),
        .o_overflow(ovf_a), .o_underflow(unf_a)
    );

    sync_fifo_v3 #(.WIDTH(8), .DEPTH_LEN(4), .FWFT(1'b0), .AF_THRESH(12), .AE_THRESH(2)) dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_flush(flush_b), .i_clr_err(clr_b),
        .i_data(din_b), .wr_en(wr_b), .rd_en(rd_b), .o_data(dout_b),
        .o_rd_valid(valid_b), .o_full(full_b), .o_empty(empty_b),
        .o_almost_full(af_b), .o_almost_empty(ae_b), .o_count(count_b),
        .o_overflow(ovf_b), .o_underflow(unf_b)
    );

    task automatic check(input string name, input int actual, input int expected);
        n_vec++;
        if (actual !== expected) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_a(input logic w, input logic r, input logic [7:0] d);
        wr_a = w; rd_a = r; din_a = d;
        tick();
    endtask

    task automatic drive_b(input logic w, input logic r, input logic [7:0] d);
        wr_b = w; rd_b = r; din_b = d;
        tick();
    endtask

    // FWFT: head word is on o_data before the edge that accepts the read.
    always @(negedge clk) begin
        if (rst_n && rd_a && !empty_a && !flush_a) begin
            if (q_a.size() == 0) check("fwft_unexpected_read", 1, 0);
            else check("fwft_data", int'(dout_a), int'(q_a.pop_front()));
        end
    end

    // Standard mode: o_data is valid in the cycle o_rd_valid pulses.
    always @(negedge clk) begin
        if (rst_n && valid_b) begin
            if (q_b.size() == 0) check("std_unexpected_valid", 1, 0);
            else check("std_data", int'(dout_b), int'(q_b.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        int bad;

        // Reset, with a write attempted while held
        rst_n = 1'b0;
        wr_a = 1'b1; din_a = 8'h77;
        tick(); tick();
        check("rst_empty",    empty_a, 1);
        check("rst_count",    count_a, 0);
        check("rst_ae",       ae_a, 1);
        check("rst_af",       af_a, 0);
        check("rst_full",     full_a, 0);
        check("rst_ovf",      ovf_a, 0);
        check("rst_unf",      unf_a, 0);
        check("rst_data",     dout_a, 0);
        check("rst_b_data",   dout_b, 0);
        check("rst_b_valid",  valid_b, 0);
        rst_n = 1'b1;
        wr_a = 1'b0;
        tick();
        check("post_rst_count", count_a, 0);

        // Fill 0x00..0x0F
        for (int i = 0; i < 16; i++) begin
            q_a.push_back(8'(i));
            drive_a(1, 0, 8'(i));
            check("fill_count", count_a, i + 1);
            check("fill_af",    af_a, (i + 1 >= 12) ? 1 : 0);
            check("fill_full",  full_a, (i + 1 == 16) ? 1 : 0);
        end
        check("full_valid", valid_a, 1);

        // Write at full is dropped and flagged
        drive_a(1, 0, 8'hAA);
        check("ovf_count", count_a, 16);
        check("ovf_flag",  ovf_a, 1);

        // Drain 16
        for (int i = 0; i < 16; i++) drive_a(0, 1, 8'h00);
        drive_a(0, 0, 8'h00);
        check("drain_empty", empty_a, 1);
        check("drain_valid", valid_a, 0);

        // Read at empty
        drive_a(0, 1, 8'h00);
        check("unf_flag",  unf_a, 1);
        check("unf_count", count_a, 0);
        clr_a = 1'b1;
        drive_a(0, 0, 8'h00);
        clr_a = 1'b0;
        check("clr_ovf", ovf_a, 0);
        check("clr_unf", unf_a, 0);

        // Simultaneous at empty: write only, underflow flagged
        q_a.push_back(8'h33);
        drive_a(1, 1, 8'h33);
        check("rw_empty_count", count_a, 1);
        check("rw_empty_unf",   unf_a, 1);
        clr_a = 1'b1;
        drive_a(0, 0, 8'h00);
        clr_a = 1'b0;

        // Bring to count 5, then 100 cycles of read+write
        for (int i = 0; i < 4; i++) begin
            q_a.push_back(8'h40 + 8'(i));
            drive_a(1, 0, 8'h40 + 8'(i));
        end
        check("count5", count_a, 5);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            q_a.push_back(8'h80 + 8'(i));
            drive_a(1, 1, 8'h80 + 8'(i));
            if (count_a != 5) bad++;
        end
        check("rw_steady_bad_cycles", bad, 0);
        check("rw_steady_count", count_a, 5);

        // Top up to full, then simultaneous at full
        for (int i = 0; i < 11; i++) begin
            q_a.push_back(8'hD0 + 8'(i));
            drive_a(1, 0, 8'hD0 + 8'(i));
        end
        check("refill_full", full_a, 1);
        drive_a(1, 1, 8'hCC);
        check("rw_full_count", count_a, 15);
        check("rw_full_ovf",   ovf_a, 1);

        // Down to 9, flush with a concurrent write
        for (int i = 0; i < 6; i++) drive_a(0, 1, 8'h00);
        check("pre_flush_count", count_a, 9);
        flush_a = 1'b1;
        drive_a(1, 0, 8'hEE);
        flush_a = 1'b0;
        q_a.delete();
        check("flush_count", count_a, 0);
        check("flush_empty", empty_a, 1);
        check("flush_ovf",   ovf_a, 1);
        check("flush_unf",   unf_a, 0);
        q_a.push_back(8'h5A);
        drive_a(1, 0, 8'h5A);
        check("post_flush_head", dout_a, 8'h5A);
        drive_a(0, 1, 8'h00);
        drive_a(0, 0, 8'h00);
        check("post_flush_empty", empty_a, 1);
        clr_a = 1'b1;
        drive_a(0, 0, 8'h00);
        clr_a = 1'b0;
        check("clr2_ovf", ovf_a, 0);

        // Async reset mid-burst
        for (int i = 0; i < 3; i++) begin
            q_a.push_back(8'h60 + 8'(i));
            drive_a(1, 0, 8'h60 + 8'(i));
        end
        wr_a = 1'b1; din_a = 8'h63;
        #2;
        rst_n = 1'b0;
        wr_a = 1'b0;
        #1;
        check("async_rst_empty", empty_a, 1);
        check("async_rst_count", count_a, 0);
        q_a.delete();
        tick();
        rst_n = 1'b1;
        q_a.push_back(8'h66);
        drive_a(1, 0, 8'h66);
        check("post_rst_count1", count_a, 1);
        drive_a(0, 1, 8'h00);
        drive_a(0, 0, 8'h00);

        // Standard mode: registered read with one-cycle latency
        q_b.push_back(8'h11);
        drive_b(1, 0, 8'h11);
        q_b.push_back(8'h22);
        drive_b(1, 0, 8'h22);
        check("std_idle_valid", valid_b, 0);
        check("std_idle_data",  dout_b, 0);
        drive_b(0, 1, 8'h00);
        check("std_rd1_valid", valid_b, 1);
        check("std_rd1_data",  dout_b, 8'h11);
        drive_b(0, 0, 8'h00);
        check("std_hold_valid", valid_b, 0);
        check("std_hold_data",  dout_b, 8'h11);
        drive_b(0, 1, 8'h00);
        check("std_rd2_valid", valid_b, 1);
        check("std_rd2_data",  dout_b, 8'h22);
        drive_b(0, 1, 8'h00);
        check("std_unf_valid", valid_b, 0);
        check("std_unf_flag",  unf_b, 1);

        // Standard mode: flush cancels a concurrent read
        drive_b(1, 0, 8'h99);
        flush_b = 1'b1;
        drive_b(0, 1, 8'h00);
        flush_b = 1'b0;
        check("std_flush_valid", valid_b, 0);
        check("std_flush_data",  dout_b, 8'h22);
        check("std_flush_count", count_b, 0);
        drive_b(0, 0, 8'h00);

        check("sb_a_leftover", q_a.size(), 0);
        check("sb_b_leftover", q_b.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
